// File: rtl/ads1115_scan_sched.sv
// Purpose: sequences a byte-level I2C master through ADS1115 single-shot conversions, scanning channels round-robin.
// Latency: START one cycle after an accepted trigger, one cycle between commands, sample one cycle after the RD STOP response.
// Backpressure: one command in flight; cmd_valid_o holds op/data until cmd_ready_i, then stays low until rsp_valid_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i, trig_i            scan enable, scan-start pulse (honoured only when idle)
//   cmd_valid_o/_ready_i    command handshake to the I2C master; cmd_op_o / cmd_data_o carry the command
//   rsp_valid_i/_data_i     command completion, read byte
//   rsp_nack_i              slave NACK on a WRITE
//   sample_valid_o/_data_o/_ch_o   tagged conversion result strobe
//   err_o, err_cnt_o        NACK-abort pulse and saturating count
//   busy_o                  scan in progress
module ads1115_scan_sched #(
  parameter logic [6:0]  I2C_ADDR  = 7'b1001001,
  parameter int          NUM_CH    = 2,
  parameter logic [2:0]  PGA       = 3'b010,
  parameter logic [2:0]  DR        = 3'b111,
  parameter int unsigned CONV_WAIT = 32400
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        trig_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [2:0]  cmd_op_o,
  output logic [7:0]  cmd_data_o,
  input  logic        rsp_valid_i,
  input  logic [7:0]  rsp_data_i,
  input  logic        rsp_nack_i,
  output logic        sample_valid_o,
  output logic [15:0] sample_data_o,
  output logic [1:0]  sample_ch_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o,
  output logic        busy_o
);

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_STOP    = 3'd1;
  localparam logic [2:0] OP_WRITE   = 3'd2;
  localparam logic [2:0] OP_RD_ACK  = 3'd3;
  localparam logic [2:0] OP_RD_NACK = 3'd4;

  typedef enum logic [2:0] {IDLE, CFG, WAIT, PTR, RD, ABORT, NEXT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q;
  logic        pend_q;       // a command has been accepted and its response is still due
  logic [1:0]  ch_q;
  logic [31:0] wait_cnt_q;
  logic [7:0]  rd_hi_q, rd_lo_q;
  logic        idle_hold_q;  // blocks a trigger on the first idle cycle after a scan ends

  logic [2:0]  cur_op;
  logic [7:0]  cur_data;
  logic        issuing, last_cmd, rsp_ok, wr_nack, last_ch;
  logic [7:0]  cfg_hi, cfg_lo, addr_w, addr_r;

  assign cfg_hi  = {1'b1, 1'b1, ch_q, PGA, 1'b1};
  assign cfg_lo  = {DR, 5'b00011};
  assign addr_w  = {I2C_ADDR, 1'b0};
  assign addr_r  = {I2C_ADDR, 1'b1};
  assign last_ch = (ch_q == 2'(NUM_CH - 1));

  // Command decode from state/step; stable for as long as the command is pending.
  always_comb begin
    cur_op   = OP_STOP;
    cur_data = 8'h00;
    last_cmd = 1'b0;
    issuing  = 1'b0;
    case (state_q)
      CFG: begin
        issuing = 1'b1;
        case (step_q)
          3'd0:    cur_op = OP_START;
          3'd1:    begin cur_op = OP_WRITE; cur_data = addr_w; end
          3'd2:    begin cur_op = OP_WRITE; cur_data = 8'h01;  end
          3'd3:    begin cur_op = OP_WRITE; cur_data = cfg_hi; end
          3'd4:    begin cur_op = OP_WRITE; cur_data = cfg_lo; end
          default: last_cmd = 1'b1;
        endcase
      end
      PTR: begin
        issuing = 1'b1;
        case (step_q)
          3'd0:    cur_op = OP_START;
          3'd1:    begin cur_op = OP_WRITE; cur_data = addr_w; end
          3'd2:    begin cur_op = OP_WRITE; cur_data = 8'h00;  end
          default: last_cmd = 1'b1;
        endcase
      end
      RD: begin
        issuing = 1'b1;
        case (step_q)
          3'd0:    cur_op = OP_START;
          3'd1:    begin cur_op = OP_WRITE; cur_data = addr_r; end
          3'd2:    cur_op = OP_RD_ACK;
          3'd3:    cur_op = OP_RD_NACK;
          default: last_cmd = 1'b1;
        endcase
      end
      ABORT: begin
        issuing  = 1'b1;
        last_cmd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_valid_o = issuing && !pend_q;
    cmd_op_o    = cmd_valid_o ? cur_op : OP_START;
    cmd_data_o  = cmd_valid_o ? cur_data : 8'h00;
    busy_o      = (state_q != IDLE);
    rsp_ok      = rsp_valid_i && pend_q;
    wr_nack     = rsp_ok && rsp_nack_i && (cur_op == OP_WRITE);

    state_d = state_q;
    case (state_q)
      IDLE:  if (trig_i && en_i && !idle_hold_q) state_d = CFG;
      CFG:   if (wr_nack) state_d = ABORT; else if (rsp_ok && last_cmd) state_d = WAIT;
      WAIT:  if (wait_cnt_q == CONV_WAIT - 1) state_d = PTR;
      PTR:   if (wr_nack) state_d = ABORT; else if (rsp_ok && last_cmd) state_d = RD;
      RD:    if (wr_nack) state_d = ABORT; else if (rsp_ok && last_cmd) state_d = NEXT;
      ABORT: if (rsp_ok) state_d = NEXT;
      NEXT:  state_d = (last_ch || !en_i) ? IDLE : CFG;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      step_q         <= 3'd0;
      pend_q         <= 1'b0;
      ch_q           <= 2'd0;
      wait_cnt_q     <= 32'd0;
      rd_hi_q        <= 8'h00;
      rd_lo_q        <= 8'h00;
      idle_hold_q    <= 1'b0;
      sample_valid_o <= 1'b0;
      sample_data_o  <= 16'h0000;
      sample_ch_o    <= 2'd0;
      err_o          <= 1'b0;
      err_cnt_o      <= 8'h00;
    end else begin
      state_q        <= state_d;
      sample_valid_o <= 1'b0;
      err_o          <= 1'b0;
      idle_hold_q    <= 1'b0;

      if (cmd_valid_o && cmd_ready_i) pend_q <= 1'b1;

      if (rsp_ok) begin
        pend_q <= 1'b0;
        step_q <= step_q + 3'd1;
        if (cur_op == OP_RD_ACK)  rd_hi_q <= rsp_data_i;
        if (cur_op == OP_RD_NACK) rd_lo_q <= rsp_data_i;
      end

      if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;

      // Every phase starts its command sequence and wait count from zero.
      if (state_d != state_q) begin
        step_q     <= 3'd0;
        wait_cnt_q <= 32'd0;
      end

      if (state_q == RD && state_d == NEXT) begin
        sample_valid_o <= 1'b1;
        sample_data_o  <= {rd_hi_q, rd_lo_q};
        sample_ch_o    <= ch_q;
      end

      if (state_q == ABORT && state_d == NEXT) begin
        err_o <= 1'b1;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end

      if (state_q == NEXT) begin
        if (state_d == IDLE) begin
          ch_q        <= 2'd0;
          idle_hold_q <= 1'b1;
        end else begin
          ch_q <= ch_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads1115_scan_sched.sv
module tb_ads1115_scan_sched;

  localparam int unsigned CW = 10;
  localparam logic [7:0] ADDR_W = 8'h92;
  localparam logic [7:0] ADDR_R = 8'h93;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, trig_i, cmd_ready_i, rsp_valid_i, rsp_nack_i;
  logic [7:0]  rsp_data_i;
  logic        cmd_valid_o, sample_valid_o, err_o, busy_o;
  logic [2:0]  cmd_op_o;
  logic [7:0]  cmd_data_o, err_cnt_o;
  logic [15:0] sample_data_o;
  logic [1:0]  sample_ch_o;

  ads1115_scan_sched #(.CONV_WAIT(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .trig_i(trig_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_data_o(cmd_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_nack_i(rsp_nack_i),
    .sample_valid_o(sample_valid_o), .sample_data_o(sample_data_o), .sample_ch_o(sample_ch_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic [1:0] tag;  // 1 cfg STOP, 2 PTR START, 3 RD START
  } exp_cmd_t;

  exp_cmd_t    exp_cmd_q[$];
  logic [17:0] exp_smp_q[$];
  logic [15:0] adc_q[$];
  logic [7:0]  cfg_hi_tbl [2] = '{8'hC5, 8'hD5};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // master model state
  bit         outstanding = 0, stalled_prev = 0, prev_busy = 0;
  int         rsp_timer = 0, stall_cfg = 0, stall_left = 0, nack_mode = 0;
  logic [2:0] prev_op;
  logic [7:0] prev_data, pend_rsp_data;
  logic       pend_rsp_nack;
  logic [1:0] pend_tag;
  int         present_cyc = 0, wait_entry_cyc = -1, ptr_start_cyc = -1;
  int         rd_start_cnt = 0, accept_cnt = 0, err_seen = 0, smp_seen = 0;
  int         last_smp_cyc = -1, busy_fall_cyc = -1;
  exp_cmd_t   ec;
  logic [15:0] w;
  logic [17:0] es;

  initial forever @(posedge clk_i) cyc++;

  // I2C master model and output monitor: everything happens on the falling edge.
  initial begin
    cmd_ready_i = 0; rsp_valid_i = 0; rsp_data_i = 0; rsp_nack_i = 0;
    forever begin
      @(negedge clk_i);
      rsp_valid_i = 0; rsp_data_i = 0; rsp_nack_i = 0; cmd_ready_i = 0;
      if (sample_valid_o) begin
        smp_seen++; last_smp_cyc = cyc; checks++;
        if (exp_smp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected got ch=%0d data=%h want none", sample_ch_o, sample_data_o);
        end else begin
          es = exp_smp_q.pop_front();
          if ({sample_ch_o, sample_data_o} !== es) begin
            errors++;
            $display("FAIL sample got ch=%0d data=%h want ch=%0d data=%h",
                     sample_ch_o, sample_data_o, es[17:16], es[15:0]);
          end
        end
      end
      if (err_o) err_seen++;
      if (prev_busy && !busy_o) busy_fall_cyc = cyc;
      prev_busy = busy_o;

      if (rst_i) begin
        outstanding = 0; stalled_prev = 0; stall_left = stall_cfg;
      end else if (outstanding) begin
        checks++;
        if (cmd_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL cmd_dup got valid=%b want 0 while outstanding", cmd_valid_o);
        end
        rsp_timer--;
        if (rsp_timer == 0) begin
          rsp_valid_i = 1; rsp_data_i = pend_rsp_data; rsp_nack_i = pend_rsp_nack;
          outstanding = 0;
          if (pend_tag == 2'd1) wait_entry_cyc = cyc + 1;
        end
      end else if (cmd_valid_o) begin
        if (stalled_prev) begin
          checks++;
          if (cmd_op_o !== prev_op || cmd_data_o !== prev_data) begin
            errors++;
            $display("FAIL cmd_stable got op=%0d data=%h want op=%0d data=%h",
                     cmd_op_o, cmd_data_o, prev_op, prev_data);
          end
        end else present_cyc = cyc;
        prev_op = cmd_op_o; prev_data = cmd_data_o;
        if (stall_left > 0) begin
          stall_left--; stalled_prev = 1;
        end else begin
          cmd_ready_i = 1; stalled_prev = 0; stall_left = stall_cfg;
          accept_cnt++; outstanding = 1; rsp_timer = 4; pend_tag = 2'd0;
          checks++;
          if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected got op=%0d data=%h want none", cmd_op_o, cmd_data_o);
          end else begin
            ec = exp_cmd_q.pop_front();
            pend_tag = ec.tag;
            if (cmd_op_o !== ec.op || cmd_data_o !== ec.data) begin
              errors++;
              $display("FAIL cmd_seq got op=%0d data=%h want op=%0d data=%h",
                       cmd_op_o, cmd_data_o, ec.op, ec.data);
            end
          end
          if (pend_tag == 2'd2) ptr_start_cyc = present_cyc;
          if (pend_tag == 2'd3) rd_start_cnt++;
          pend_rsp_data = 8'h00; pend_rsp_nack = 1'b0;
          case (cmd_op_o)
            3'd2: begin
              if (nack_mode == 2) pend_rsp_nack = 1'b1;
              else if (nack_mode == 1) begin pend_rsp_nack = 1'b1; nack_mode = 0; end
            end
            3'd3: if (adc_q.size() != 0) begin w = adc_q[0]; pend_rsp_data = w[15:8]; end
            3'd4: if (adc_q.size() != 0) begin w = adc_q.pop_front(); pend_rsp_data = w[7:0]; end
            default: ;
          endcase
        end
      end else begin
        if (stalled_prev) begin
          checks++; errors++;
          $display("FAIL cmd_withdrawn got valid=0 want 1 until accepted");
        end
        stalled_prev = 0;
      end
    end
  end

  function automatic void push_cmd(logic [2:0] op, logic [7:0] d, logic [1:0] tag);
    exp_cmd_t c;
    c.op = op; c.data = d; c.tag = tag;
    exp_cmd_q.push_back(c);
  endfunction

  function automatic void push_channel(int ch, logic [15:0] word);
    logic [1:0] c2;
    c2 = 2'(ch);
    push_cmd(3'd0, 8'h00, 2'd0); push_cmd(3'd2, ADDR_W, 2'd0); push_cmd(3'd2, 8'h01, 2'd0);
    push_cmd(3'd2, cfg_hi_tbl[ch], 2'd0); push_cmd(3'd2, 8'hE3, 2'd0); push_cmd(3'd1, 8'h00, 2'd1);
    push_cmd(3'd0, 8'h00, 2'd2); push_cmd(3'd2, ADDR_W, 2'd0); push_cmd(3'd2, 8'h00, 2'd0);
    push_cmd(3'd1, 8'h00, 2'd0);
    push_cmd(3'd0, 8'h00, 2'd3); push_cmd(3'd2, ADDR_R, 2'd0); push_cmd(3'd3, 8'h00, 2'd0);
    push_cmd(3'd4, 8'h00, 2'd0); push_cmd(3'd1, 8'h00, 2'd0);
    adc_q.push_back(word);
    exp_smp_q.push_back({c2, word});
  endfunction

  function automatic void push_abort_ch();
    push_cmd(3'd0, 8'h00, 2'd0); push_cmd(3'd2, ADDR_W, 2'd0); push_cmd(3'd1, 8'h00, 2'd0);
  endfunction

  task automatic pulse_trig();
    @(posedge clk_i); #1 trig_i = 1;
    @(posedge clk_i); #1 trig_i = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((exp_cmd_q.size() != 0 || exp_smp_q.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk_i); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout got cmds_left=%0d smps_left=%0d busy=%b want 0 0 0",
               name, exp_cmd_q.size(), exp_smp_q.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({cmd_valid_o, cmd_op_o, cmd_data_o} !== 12'h000) begin
      errors++; $display("FAIL reset_cmd got %b %0d %h want 0 0 00", cmd_valid_o, cmd_op_o, cmd_data_o);
    end
    checks++;
    if ({sample_valid_o, sample_ch_o, sample_data_o} !== 19'h0) begin
      errors++; $display("FAIL reset_sample got %b %0d %h want 0", sample_valid_o, sample_ch_o, sample_data_o);
    end
    checks++;
    if ({err_o, err_cnt_o, busy_o} !== 10'h0) begin
      errors++; $display("FAIL reset_err_busy got %b %0d %b want 0 0 0", err_o, err_cnt_o, busy_o);
    end
    @(posedge clk_i); #1 rst_i = 0;
  endtask

  task automatic test_single_scan();
    int s0;
    @(posedge clk_i); #1 en_i = 1;
    push_channel(0, 16'h4123); push_channel(1, 16'h4321);
    s0 = smp_seen;
    pulse_trig();
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || cmd_valid_o !== 1'b1 || cmd_op_o !== 3'd0) begin
      errors++; $display("FAIL trig_start got busy=%b valid=%b op=%0d want 1 1 0", busy_o, cmd_valid_o, cmd_op_o);
    end
    wait_done(2000, "single");
    checks++;
    if (smp_seen - s0 != 2) begin errors++; $display("FAIL single_count got %0d want 2", smp_seen - s0); end
    checks++;
    if (busy_fall_cyc != last_smp_cyc + 1) begin
      errors++; $display("FAIL busy_fall got cyc %0d want %0d", busy_fall_cyc, last_smp_cyc + 1);
    end
    @(negedge clk_i);
    checks++;
    if (sample_data_o !== 16'h4321 || sample_ch_o !== 2'd1) begin
      errors++; $display("FAIL sample_hold got ch=%0d data=%h want 1 4321", sample_ch_o, sample_data_o);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    push_channel(0, 16'h4123); push_channel(1, 16'h4321);
    s0 = smp_seen;
    @(posedge clk_i); #1 stall_cfg = 7; stall_left = 7;
    pulse_trig();
    wait_done(6000, "backpressure");
    checks++;
    if (smp_seen - s0 != 2) begin errors++; $display("FAIL bp_count got %0d want 2", smp_seen - s0); end
    @(posedge clk_i); #1 stall_cfg = 0; stall_left = 0;
  endtask

  task automatic test_nack();
    int s0, e0;
    push_abort_ch(); push_channel(1, 16'h1234);
    s0 = smp_seen; e0 = err_seen;
    @(posedge clk_i); #1 nack_mode = 1;
    pulse_trig();
    wait_done(2000, "nack");
    checks++;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL nack_err_pulse got %0d want 1", err_seen - e0); end
    checks++;
    if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL nack_err_cnt got %0d want 1", err_cnt_o); end
    checks++;
    if (smp_seen - s0 != 1) begin errors++; $display("FAIL nack_count got %0d want 1", smp_seen - s0); end
  endtask

  task automatic test_trig_en();
    int we, r, n, seen, s0;
    push_channel(0, 16'h0ABC);
    we = wait_entry_cyc; r = rd_start_cnt; s0 = smp_seen;
    pulse_trig();
    n = 0;
    while (wait_entry_cyc == we && n < 300) begin @(negedge clk_i); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL te_wait_timeout got no WAIT entry want one"); end
    pulse_trig();
    n = 0;
    while (rd_start_cnt == r && n < 300) begin @(negedge clk_i); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL te_rd_timeout got no RD START want one"); end
    @(posedge clk_i); #1 en_i = 0;
    wait_done(2000, "trig_en");
    seen = 0;
    repeat (40) begin @(negedge clk_i); if (cmd_valid_o) seen++; end
    checks++;
    if (seen != 0 || busy_o) begin errors++; $display("FAIL te_idle got valid_cycles=%0d busy=%b want 0 0", seen, busy_o); end
    checks++;
    if (smp_seen - s0 != 1 || sample_ch_o !== 2'd0) begin
      errors++; $display("FAIL te_sample got count=%0d ch=%0d want 1 0", smp_seen - s0, sample_ch_o);
    end
  endtask

  task automatic test_reset_mid();
    int a, n, s0;
    @(posedge clk_i); #1 en_i = 1;
    push_channel(0, 16'h5555); push_channel(1, 16'h6666);
    a = accept_cnt;
    pulse_trig();
    n = 0;
    while (accept_cnt < a + 2 && n < 100) begin @(negedge clk_i); n++; end
    @(posedge clk_i); #1 rst_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({cmd_valid_o, cmd_op_o, cmd_data_o, sample_valid_o, sample_ch_o, sample_data_o} !== 31'h0) begin
      errors++; $display("FAIL rstmid_out got valid=%b op=%0d data=%h sv=%b ch=%0d sd=%h want all 0",
                         cmd_valid_o, cmd_op_o, cmd_data_o, sample_valid_o, sample_ch_o, sample_data_o);
    end
    checks++;
    if ({err_o, err_cnt_o, busy_o} !== 10'h0) begin
      errors++; $display("FAIL rstmid_state got err=%b cnt=%0d busy=%b want 0 0 0", err_o, err_cnt_o, busy_o);
    end
    exp_cmd_q.delete(); exp_smp_q.delete(); adc_q.delete();
    @(posedge clk_i); #1 rst_i = 0;
    push_channel(0, 16'h7A01); push_channel(1, 16'h8B02);
    s0 = smp_seen;
    pulse_trig();
    @(negedge clk_i);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_op_o !== 3'd0) begin
      errors++; $display("FAIL rstmid_restart got valid=%b op=%0d want 1 0", cmd_valid_o, cmd_op_o);
    end
    wait_done(2000, "rstmid");
    checks++;
    if (smp_seen - s0 != 2) begin errors++; $display("FAIL rstmid_count got %0d want 2", smp_seen - s0); end
  endtask

  task automatic test_conv_wait();
    int we, n, seen;
    push_channel(0, 16'h1111); push_channel(1, 16'h2222);
    we = wait_entry_cyc;
    pulse_trig();
    n = 0;
    while (wait_entry_cyc == we && n < 300) begin @(negedge clk_i); n++; end
    pulse_trig();  // lands while busy and must be dropped
    wait_done(2000, "conv_wait");
    checks++;
    if (ptr_start_cyc - wait_entry_cyc != int'(CW)) begin
      errors++; $display("FAIL conv_wait got %0d want %0d", ptr_start_cyc - wait_entry_cyc, CW);
    end
    seen = 0;
    repeat (40) begin @(negedge clk_i); if (cmd_valid_o) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL trig_busy_drop got valid_cycles=%0d want 0", seen); end
  endtask

  task automatic test_err_sat();
    int e0;
    e0 = err_seen;
    @(posedge clk_i); #1 nack_mode = 2;
    for (int i = 0; i < 150; i++) begin
      push_abort_ch(); push_abort_ch();
      pulse_trig();
      wait_done(500, "err_sat");
      if (i == 126) begin
        checks++;
        if (err_cnt_o !== 8'd254) begin errors++; $display("FAIL err_cnt_254 got %0d want 254", err_cnt_o); end
      end
    end
    checks++;
    if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt_o); end
    checks++;
    if (err_seen - e0 != 300) begin errors++; $display("FAIL err_pulses got %0d want 300", err_seen - e0); end
    @(posedge clk_i); #1 nack_mode = 0;
  endtask

  initial begin
    rst_i = 1; en_i = 0; trig_i = 0;
    test_reset();
    test_single_scan();
    test_backpressure();
    test_nack();
    test_trig_en();
    test_reset_mid();
    test_conv_wait();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
